// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider (DIV/DIVU) feeding the HI/LO pair.
// Results are loaded on the SIGN edge and announced by a one-cycle done strobe.

// seq_divider_checker: handshake properties of the divider outputs.
module seq_divider_checker (
    input logic clk,
    input logic reset,
    input logic busy,
    input logic done
);
    a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(busy && done));
    a_done_single:    assert property (@(posedge clk) disable iff (reset) done |=> !done);
endmodule

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  ZERO_C    = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = negate(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic             is_signed_r;
    logic             dvd_neg_r;
    logic             dvs_neg_r;
    logic             dvs_zero_r;
    logic [WIDTH-1:0] dvs_mag_r;
    logic [WIDTH-1:0] dvd_orig_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic             is_div_s;
    logic             funct_ok_s;
    logic             accept_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             trial_ok_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] q_final_s;
    logic [WIDTH-1:0] r_final_s;

    // Request decode: new work is taken only in IDLE or DONE (back-to-back).
    always_comb begin
        is_div_s   = (funct == FUNCT_DIV);
        funct_ok_s = is_div_s || (funct == FUNCT_DIVU);
        if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
            accept_s = start && funct_ok_s;
        end else begin
            accept_s = 1'b0;
        end
    end

    // One restoring step; a set top bit in the shifted remainder always exceeds the divisor.
    always_comb begin
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        trial_s    = shifted_s - {1'b0, dvs_mag_r};
        trial_ok_s = shifted_s[WIDTH] | ~trial_s[WIDTH];
        if (trial_ok_s) begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fixup; divide-by-zero bypasses it and returns the original dividend.
    always_comb begin
        if (dvs_zero_r) begin
            q_final_s = ONES_W;
            r_final_s = dvd_orig_r;
        end else if (is_signed_r) begin
            if (dvd_neg_r ^ dvs_neg_r) begin
                q_final_s = negate(quo_r);
            end else begin
                q_final_s = quo_r;
            end
            if (dvd_neg_r) begin
                r_final_s = negate(rem_r);
            end else begin
                r_final_s = rem_r;
            end
        end else begin
            q_final_s = quo_r;
            r_final_s = rem_r;
        end
    end

    // Control FSM with registered busy/done/div_by_zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= ZERO_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    dbz_r  <= 1'b0;
                    if (accept_s) begin
                        state_r <= S_RUN;
                        busy_r  <= 1'b1;
                        cnt_r   <= ZERO_C;
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt_r <= cnt_r + ONE_C;
                    if (cnt_r == LAST_ITER) begin
                        state_r <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    state_r <= S_DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    dbz_r   <= dvs_zero_r;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture on acceptance, then one shift/subtract per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_signed_r <= 1'b0;
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            dvs_zero_r  <= 1'b0;
            dvs_mag_r   <= ZERO_W;
            dvd_orig_r  <= ZERO_W;
            rem_r       <= ZERO_W;
            quo_r       <= ZERO_W;
        end else if (accept_s) begin
            is_signed_r <= is_div_s;
            dvd_neg_r   <= is_div_s & dividend[WIDTH-1];
            dvs_neg_r   <= is_div_s & divisor[WIDTH-1];
            dvs_zero_r  <= (divisor == ZERO_W);
            dvs_mag_r   <= magnitude(divisor, is_div_s);
            dvd_orig_r  <= dividend;
            rem_r       <= ZERO_W;
            quo_r       <= magnitude(dividend, is_div_s);
        end else if (state_r == S_RUN) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
        end
    end

    // HI/LO result registers, written once per operation on the SIGN edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
        end else if (state_r == S_SIGN) begin
            quotient_r  <= q_final_s;
            remainder_r <= r_final_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

    seq_divider_checker u_checker (
        .clk   (clk),
        .reset (reset),
        .busy  (busy_r),
        .done  (done_r)
    );
endmodule
